// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared definitions for the TLB maintenance controller: entry layout, MAS field
// positions, command encodings and controller state enum.
package tlb_maint_ctrl_pkg;

    localparam int NENTRY  = 16;
    localparam int IDX_W   = 4;
    localparam int ENTRY_W = 72;

    // Packed entry layout, LSB offsets (MSB->LSB: V, IPROT, TID, TS, TSIZE, EPN, X0X1, WIMGE, RPN, U0_U3, PERMIS)
    localparam int E_PERMIS_LSB = 0;
    localparam int E_PERMIS_W   = 6;
    localparam int E_U_LSB      = 6;
    localparam int E_U_W        = 4;
    localparam int E_RPN_LSB    = 10;
    localparam int E_RPN_W      = 20;
    localparam int E_WIMGE_LSB  = 30;
    localparam int E_WIMGE_W    = 5;
    localparam int E_X_LSB      = 35;
    localparam int E_X_W        = 2;
    localparam int E_EPN_LSB    = 37;
    localparam int E_EPN_W      = 20;
    localparam int E_TSIZE_LSB  = 57;
    localparam int E_TSIZE_W    = 4;
    localparam int E_TS_BIT     = 61;
    localparam int E_TID_LSB    = 62;
    localparam int E_TID_W      = 8;
    localparam int E_IPROT_BIT  = 70;
    localparam int E_V_BIT      = 71;

    localparam logic [1:0] OP_TLBWE = 2'b00;
    localparam logic [1:0] OP_TLBRE = 2'b01;
    localparam logic [1:0] OP_FLASH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam int MAS0_ESEL_LSB    = 12;
    localparam int MAS0_TLBSEL_LSB  = 28;
    localparam int MAS1_V_BIT       = 0;
    localparam int MAS1_IPROT_BIT   = 1;
    localparam int MAS1_TID_LSB     = 8;
    localparam int MAS1_TS_BIT      = 19;
    localparam int MAS1_TSIZE_LSB   = 20;
    localparam int MAS2_EPN_LSB     = 12;
    localparam int MAS2_X_LSB       = 5;
    localparam int MAS2_WIMGE_LSB   = 0;
    localparam int MAS3_RPN_LSB     = 12;
    localparam int MAS3_U_LSB       = 6;
    localparam int MAS3_PERMIS_LSB  = 0;
    localparam int MAS4_TLBSELD_LSB = 28;
    localparam int MAS4_TSIZED_LSB  = 8;
    localparam int MAS4_XD_LSB      = 5;
    localparam int MAS4_WIMGED_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_FL_RD,
        ST_FL_WR,
        ST_MISS_LD
    } state_e;

endpackage

// File: rtl/tlb_entry_pack.sv
// Combinational MAS1..MAS3 <-> packed TLB entry conversion, shared by the IMMU and DMMU.
module tlb_entry_pack
    import tlb_maint_ctrl_pkg::*;
(
    input  logic [31:0]        pk_mas1,
    input  logic [31:0]        pk_mas2,
    input  logic [31:0]        pk_mas3,
    output logic [ENTRY_W-1:0] pk_entry,
    input  logic [ENTRY_W-1:0] up_entry,
    output logic [31:0]        up_mas1,
    output logic [31:0]        up_mas2,
    output logic [31:0]        up_mas3
);

    // MAS bits with no entry field are simply dropped.
    logic unused_pk;
    assign unused_pk = ^{pk_mas1, pk_mas2, pk_mas3};

    always_comb begin
        pk_entry = '0;
        pk_entry[E_V_BIT]                       = pk_mas1[MAS1_V_BIT];
        pk_entry[E_IPROT_BIT]                   = pk_mas1[MAS1_IPROT_BIT];
        pk_entry[E_TID_LSB +: E_TID_W]          = pk_mas1[MAS1_TID_LSB +: E_TID_W];
        pk_entry[E_TS_BIT]                      = pk_mas1[MAS1_TS_BIT];
        pk_entry[E_TSIZE_LSB +: E_TSIZE_W]      = pk_mas1[MAS1_TSIZE_LSB +: E_TSIZE_W];
        pk_entry[E_EPN_LSB +: E_EPN_W]          = pk_mas2[MAS2_EPN_LSB +: E_EPN_W];
        pk_entry[E_X_LSB +: E_X_W]              = pk_mas2[MAS2_X_LSB +: E_X_W];
        pk_entry[E_WIMGE_LSB +: E_WIMGE_W]      = pk_mas2[MAS2_WIMGE_LSB +: E_WIMGE_W];
        pk_entry[E_RPN_LSB +: E_RPN_W]          = pk_mas3[MAS3_RPN_LSB +: E_RPN_W];
        pk_entry[E_U_LSB +: E_U_W]              = pk_mas3[MAS3_U_LSB +: E_U_W];
        pk_entry[E_PERMIS_LSB +: E_PERMIS_W]    = pk_mas3[MAS3_PERMIS_LSB +: E_PERMIS_W];
    end

    always_comb begin
        up_mas1 = '0;
        up_mas2 = '0;
        up_mas3 = '0;
        up_mas1[MAS1_V_BIT]                     = up_entry[E_V_BIT];
        up_mas1[MAS1_IPROT_BIT]                 = up_entry[E_IPROT_BIT];
        up_mas1[MAS1_TID_LSB +: E_TID_W]        = up_entry[E_TID_LSB +: E_TID_W];
        up_mas1[MAS1_TS_BIT]                    = up_entry[E_TS_BIT];
        up_mas1[MAS1_TSIZE_LSB +: E_TSIZE_W]    = up_entry[E_TSIZE_LSB +: E_TSIZE_W];
        up_mas2[MAS2_EPN_LSB +: E_EPN_W]        = up_entry[E_EPN_LSB +: E_EPN_W];
        up_mas2[MAS2_X_LSB +: E_X_W]            = up_entry[E_X_LSB +: E_X_W];
        up_mas2[MAS2_WIMGE_LSB +: E_WIMGE_W]    = up_entry[E_WIMGE_LSB +: E_WIMGE_W];
        up_mas3[MAS3_RPN_LSB +: E_RPN_W]        = up_entry[E_RPN_LSB +: E_RPN_W];
        up_mas3[MAS3_U_LSB +: E_U_W]            = up_entry[E_U_LSB +: E_U_W];
        up_mas3[MAS3_PERMIS_LSB +: E_PERMIS_W]  = up_entry[E_PERMIS_LSB +: E_PERMIS_W];
    end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance controller: tlbwe, tlbre, flash invalidate and IMMU miss default loading.
// Flash-invalidate sweep is built only with TLB_FLASH_INV_EN defined; otherwise op 10 is reserved.
module tlb_maint_ctrl
    import tlb_maint_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    output logic               cmd_ready,
    input  logic [31:0]        mas0_in,
    input  logic [31:0]        mas1_in,
    input  logic [31:0]        mas2_in,
    input  logic [31:0]        mas3_in,
    input  logic [31:0]        mas4_in,
    input  logic               miss,
    input  logic [19:0]        miss_epn,
    input  logic               miss_is,
    input  logic [7:0]         pid0,
    output logic               miss_ack,
    output logic [3:0]         mas_we,
    output logic [31:0]        mas0_out,
    output logic [31:0]        mas1_out,
    output logic [31:0]        mas2_out,
    output logic [31:0]        mas3_out,
    output logic               tlb_we,
    output logic [3:0]         tlb_idx,
    output logic [ENTRY_W-1:0] tlb_wdata,
    output logic               tlb_re,
    input  logic [ENTRY_W-1:0] tlb_rdata,
    output logic               done,
    output logic               err,
    output logic [3:0]         nv
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] esel_q, esel_d;
    logic [IDX_W-1:0] nv_q, nv_d;
    logic             err_q, err_d;

    logic [ENTRY_W-1:0] pk_entry;
    logic [31:0]        up_mas1, up_mas2, up_mas3;
    logic [ENTRY_W-1:0] fl_wdata;

    logic unused_in;
    assign unused_in = ^{mas0_in, mas4_in};

    tlb_entry_pack u_pack (
        .pk_mas1  (mas1_in),
        .pk_mas2  (mas2_in),
        .pk_mas3  (mas3_in),
        .pk_entry (pk_entry),
        .up_entry (tlb_rdata),
        .up_mas1  (up_mas1),
        .up_mas2  (up_mas2),
        .up_mas3  (up_mas3)
    );

    always_comb begin
        fl_wdata          = tlb_rdata;
        fl_wdata[E_V_BIT] = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        esel_d    = esel_q;
        nv_d      = nv_q;
        err_d     = 1'b0;
        cmd_ready = 1'b0;
        miss_ack  = 1'b0;
        mas_we    = 4'b0000;
        mas0_out  = '0;
        mas1_out  = '0;
        mas2_out  = '0;
        mas3_out  = '0;
        tlb_we    = 1'b0;
        tlb_re    = 1'b0;
        tlb_idx   = '0;
        tlb_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A rejected op reports done/err from IDLE, one cycle after accept.
                done      = err_q;
                err       = err_q;
                cmd_ready = !miss && !err_q;
                if (miss) begin
                    state_d = ST_MISS_LD;
                end else if (cmd_valid && !err_q) begin
                    esel_d = mas0_in[MAS0_ESEL_LSB +: IDX_W];
                    k_d    = '0;
                    case (cmd_op)
                        OP_TLBWE: state_d = ST_WRITE;
                        OP_TLBRE: state_d = ST_RD_REQ;
`ifdef TLB_FLASH_INV_EN
                        OP_FLASH: state_d = ST_FL_RD;
`endif
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            ST_WRITE: begin
                tlb_we    = 1'b1;
                tlb_idx   = esel_q;
                tlb_wdata = pk_entry;
                done      = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RD_REQ: begin
                tlb_re  = 1'b1;
                tlb_idx = esel_q;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                mas1_out = up_mas1;
                mas2_out = up_mas2;
                mas3_out = up_mas3;
                mas_we   = 4'b1110;
                done     = 1'b1;
                state_d  = ST_IDLE;
            end
`ifdef TLB_FLASH_INV_EN
            ST_FL_RD: begin
                tlb_re  = 1'b1;
                tlb_idx = k_q;
                state_d = ST_FL_WR;
            end
            ST_FL_WR: begin
                tlb_idx = k_q;
                // Protected entries survive the flash untouched.
                if (!tlb_rdata[E_IPROT_BIT]) begin
                    tlb_we    = 1'b1;
                    tlb_wdata = fl_wdata;
                end
                k_d = k_q + IDX_W'(1);
                if (k_q == IDX_W'(NENTRY - 1)) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FL_RD;
                end
            end
`endif
            ST_MISS_LD: begin
                mas0_out[MAS0_ESEL_LSB +: IDX_W]          = nv_q;
                mas0_out[MAS0_TLBSEL_LSB]                 = mas4_in[MAS4_TLBSELD_LSB];
                mas1_out[MAS1_V_BIT]                      = 1'b1;
                mas1_out[MAS1_TID_LSB +: E_TID_W]         = pid0;
                mas1_out[MAS1_TS_BIT]                     = miss_is;
                mas1_out[MAS1_TSIZE_LSB +: E_TSIZE_W]     = mas4_in[MAS4_TSIZED_LSB +: E_TSIZE_W];
                mas2_out[MAS2_EPN_LSB +: E_EPN_W]         = miss_epn;
                mas2_out[MAS2_X_LSB +: E_X_W]             = mas4_in[MAS4_XD_LSB +: E_X_W];
                mas2_out[MAS2_WIMGE_LSB +: E_WIMGE_W]     = mas4_in[MAS4_WIMGED_LSB +: E_WIMGE_W];
                mas_we   = 4'b0111;
                miss_ack = 1'b1;
                nv_d     = nv_q + IDX_W'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign nv = nv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            esel_q  <= '0;
            nv_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            esel_q  <= esel_d;
            nv_q    <= nv_d;
            err_q   <= err_d;
        end
    end

endmodule
